// File: rtl/branch_issue_pkg.sv
// branch_issue_pkg: shared wavefront constants and issue FSM encodings for the branch issue arbiter
package branch_issue_pkg;
  localparam int WF_PER_CU = 40;
  localparam int WF_ID_LENGTH = 6;
  typedef logic [WF_ID_LENGTH-1:0] wfid_t;
  localparam wfid_t LAST_WFID = wfid_t'(WF_PER_CU - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request at or after ptr, scanning upward with wrap (rotate, find-first, modulo add)
module rr_priority_picker #(
  parameter int W = 40,
  parameter int IW = 6
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [W-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  // rotate so ptr sits at bit 0, take the lowest set bit, then map the offset back to an absolute index
  always_comb begin
    for (int i = 0; i < W; i++)
      rot[i] = req[(i + int'(ptr)) >= W ? i + int'(ptr) - W : i + int'(ptr)];
    off = '0;
    for (int i = W - 1; i >= 0; i--)
      if (rot[i]) off = IW'(i);
    found = |rot;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = sum >= (IW+1)'(W) ? IW'(sum - (IW+1)'(W)) : sum[IW-1:0];
  end
endmodule

// File: rtl/branch_issue_arbiter.sv
// branch_issue_arbiter: round-robin ALU/SALU issue grant that skips wavefronts with a pending or in-flight branch; BRANCH_ARB_STALL_STATS_EN adds stall_cnt
module branch_issue_arbiter
  import branch_issue_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    wf_ready_arry,
  input  logic [WF_PER_CU-1:0]    wf_branch_arry,
  input  logic [WF_PER_CU-1:0]    pending_branches_arry,
  input  logic                    wf_kill_en,
  input  logic [WF_ID_LENGTH-1:0] wf_kill_wfid,
  input  logic                    issue_ready,
  output logic                    issue_valid,
  output logic [WF_ID_LENGTH-1:0] issue_wfid,
  output logic                    issue_branch,
  output logic                    issue_fire
`ifdef BRANCH_ARB_STALL_STATS_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);
  logic [0:0] state;
  wfid_t rr_ptr, pick;
  logic [WF_PER_CU-1:0] shadow, shadow_next, eligible;
  logic found, kill_ok, kill_grant;
  assign eligible = wf_ready_arry & ~pending_branches_arry & ~shadow;
  assign issue_valid = state == GRANT;
  assign issue_fire = issue_valid & issue_ready & rst;
  assign kill_ok = wf_kill_en & (wf_kill_wfid < wfid_t'(WF_PER_CU));
  assign kill_grant = kill_ok & issue_valid & ~issue_ready & (wf_kill_wfid == issue_wfid);
  rr_priority_picker #(.W(WF_PER_CU), .IW(WF_ID_LENGTH)) u_picker (
    .req  (eligible),
    .ptr  (rr_ptr),
    .found(found),
    .idx  (pick)
  );
  // shadow covers issued branches until the tracker's pending bit shows up; a kill clears it even on the firing cycle
  always_comb begin
    shadow_next = shadow & ~pending_branches_arry;
    if (issue_fire && issue_branch) shadow_next[issue_wfid] = 1'b1;
    if (kill_ok) shadow_next[wf_kill_wfid] = 1'b0;
  end
  // issue FSM: register the pick in IDLE, hold it in GRANT until accepted or killed
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      shadow <= '0;
      issue_wfid <= '0;
      issue_branch <= 1'b0;
    end else begin
      shadow <= shadow_next;
      if (state == IDLE) begin
        if (found) begin
          state <= GRANT;
          issue_wfid <= pick;
          issue_branch <= wf_branch_arry[pick];
        end
      end else if (issue_ready) begin
        state <= IDLE;
        rr_ptr <= issue_wfid == LAST_WFID ? '0 : issue_wfid + 1'b1;
      end else if (kill_grant) begin
        state <= IDLE;
      end
    end
  end
`ifdef BRANCH_ARB_STALL_STATS_EN
  logic stall_cond;
  assign stall_cond = (state == IDLE) & |(wf_ready_arry & pending_branches_arry) & ~|eligible;
  // saturating count of idle cycles blocked only by pending branches
  always_ff @(posedge clk) begin
    if (!rst) stall_cnt <= '0;
    else if (stall_cond && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_branch_issue_arbiter.sv
// tb_branch_issue_arbiter: directed plus randomized checks of branch_issue_arbiter against a cycle-level reference model
module tb_branch_issue_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [39:0] ready = '0, branch = '0, pending = '0;
  logic kill_en = 1'b0;
  logic [5:0] kill_id = '0;
  logic ir = 1'b0;
  logic issue_valid, issue_branch, issue_fire;
  logic [5:0] issue_wfid;
`ifdef BRANCH_ARB_STALL_STATS_EN
  logic [31:0] stall_cnt;
  int m_stall = 0;
  int s0;
`endif
  int checks = 0;
  int errors = 0;
  bit m_valid = 0;
  bit m_branch = 0;
  int m_wfid = 0;
  int m_ptr = 0;
  bit [39:0] m_sh = '0;

  branch_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .wf_ready_arry(ready), .wf_branch_arry(branch), .pending_branches_arry(pending),
    .wf_kill_en(kill_en), .wf_kill_wfid(kill_id), .issue_ready(ir),
    .issue_valid(issue_valid), .issue_wfid(issue_wfid), .issue_branch(issue_branch),
    .issue_fire(issue_fire)
`ifdef BRANCH_ARB_STALL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int pick;
    int j;
    bit fire, kill_ok;
    @(negedge clk);
    chk("valid", 32'(issue_valid), 32'(m_valid));
    if (m_valid) begin
      chk("wfid", 32'(issue_wfid), 32'(m_wfid));
      chk("branch", 32'(issue_branch), 32'(m_branch));
    end
    chk("fire", 32'(issue_fire), 32'(m_valid & ir & rst));
`ifdef BRANCH_ARB_STALL_STATS_EN
    chk("stall", stall_cnt, 32'(m_stall));
`endif
    fire = m_valid && ir && rst;
    kill_ok = kill_en && kill_id < 40;
    pick = -1;
    for (int k = 0; k < 40; k++) begin
      j = (m_ptr + k) % 40;
      if (pick < 0 && ready[j] && !pending[j] && !m_sh[j]) pick = j;
    end
    if (!rst) begin
      m_valid = 0; m_branch = 0; m_wfid = 0; m_ptr = 0; m_sh = '0;
`ifdef BRANCH_ARB_STALL_STATS_EN
      m_stall = 0;
`endif
    end else begin
`ifdef BRANCH_ARB_STALL_STATS_EN
      if (!m_valid && (ready & pending) != 0 && pick < 0) m_stall++;
`endif
      for (int i = 0; i < 40; i++) if (pending[i]) m_sh[i] = 0;
      if (fire && m_branch) m_sh[m_wfid] = 1;
      if (kill_ok) m_sh[kill_id] = 0;
      if (m_valid) begin
        if (ir) begin
          m_ptr = (m_wfid + 1) % 40;
          m_valid = 0;
        end else if (kill_ok && kill_id == m_wfid) m_valid = 0;
      end else if (pick >= 0) begin
        m_valid = 1;
        m_wfid = pick;
        m_branch = branch[pick];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    tick();
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_wfid", 32'(issue_wfid), 0);
    chk("rst_branch", 32'(issue_branch), 0);
    rst = 1'b1;
    ready[3] = 1'b1; ready[7] = 1'b1;
    tick();
    chk("t1_first", 32'(issue_wfid), 3);
    ir = 1'b1;
    tick();
    chk("t1_idle", 32'(issue_valid), 0);
    tick();
    chk("t1_second", 32'(issue_wfid), 7);
    tick();
    ready = '0;
    ready[5] = 1'b1; branch[5] = 1'b1;
    tick();
    chk("t2_grant", 32'(issue_wfid), 5);
    tick();
    tick();
    chk("t2_shadow", 32'(issue_valid), 0);
    pending[5] = 1'b1;
    tick();
    chk("t2_pend", 32'(issue_valid), 0);
    pending = '0;
    tick();
    chk("t2_regrant", 32'(issue_valid), 1);
    chk("t2_regrant_id", 32'(issue_wfid), 5);
    ready = '0;
    tick();
    pending[5] = 1'b1;
    tick();
    pending = '0; branch = '0;
    ready[39] = 1'b1;
    tick();
    chk("t3_g39", 32'(issue_wfid), 39);
    tick();
    ready[0] = 1'b1;
    tick();
    chk("t3_wrap", 32'(issue_wfid), 0);
    tick();
    ready = '0; ir = 1'b0;
    ready[12] = 1'b1; branch[12] = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("t4_hold_id", 32'(issue_wfid), 12);
      chk("t4_hold_br", 32'(issue_branch), 1);
    end
    kill_en = 1'b1; kill_id = 6'd12; ready = '0;
    tick();
    chk("t4_drop", 32'(issue_valid), 0);
    kill_en = 1'b0;
    ready = '1; pending = '1; branch = '0;
`ifdef BRANCH_ARB_STALL_STATS_EN
    s0 = int'(stall_cnt);
`endif
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t5_block", 32'(issue_valid), 0);
    end
`ifdef BRANCH_ARB_STALL_STATS_EN
    chk("t5_stall", stall_cnt, 32'(s0 + 5));
`endif
    ready = '0; pending = '0;
    ready[20] = 1'b1; branch[20] = 1'b1;
    tick();
    ir = 1'b1; kill_en = 1'b1; kill_id = 6'd20;
    #1;
    chk("t6_fire", 32'(issue_fire), 1);
    tick();
    kill_en = 1'b0; ir = 1'b0;
    tick();
    chk("t6_noshadow", 32'(issue_valid), 1);
    chk("t6_noshadow_id", 32'(issue_wfid), 20);
    ready = '0; branch = '0;
    rst = 1'b0; ir = 1'b1;
    #1;
    chk("t7_rst_nofire", 32'(issue_fire), 0);
    tick();
    chk("t7_rst_valid", 32'(issue_valid), 0);
    rst = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(99) != 0;
      for (int i = 0; i < 40; i++) begin
        ready[i] = $urandom_range(3) == 0;
        branch[i] = $urandom_range(1) == 1;
        pending[i] = $urandom_range(9) == 0;
      end
      ir = $urandom_range(1) == 1;
      kill_en = $urandom_range(9) == 0;
      kill_id = $urandom_range(1) == 1 ? 6'(m_wfid) : 6'($urandom_range(63));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_issue_arbiter.md
Name: branch_issue_arbiter

Overview:
Round-robin scheduler that selects the next wavefront to issue to the ALU/SALU pipe. It excludes any wavefront with a pending branch and any wavefront already issued a branch whose pending bit has not yet appeared. It consumes pending_branches_arry from the branch tracking register and drives a valid/ready grant to the issue datapath. Its issued-branch output feeds the branch tracker's alu_valid/alu_branch inputs.

Parameters:
WF_PER_CU, 40, number of wavefront slots (shared constant)
WF_ID_LENGTH, 6, wavefront id width (shared constant)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
wf_ready_arry  in  WF_PER_CU  wavefront has a decoded instruction ready to issue
wf_branch_arry  in  WF_PER_CU  that ready instruction is a branch
pending_branches_arry  in  WF_PER_CU  registered pending-branch mask from the branch tracker
wf_kill_en  in  1  wavefront killed/halted this cycle
wf_kill_wfid  in  WF_ID_LENGTH  id of the killed wavefront
issue_ready  in  1  downstream accepts the grant this cycle
issue_valid  out  1  grant valid
issue_wfid  out  WF_ID_LENGTH  granted wavefront
issue_branch  out  1  granted instruction is a branch
issue_fire  out  1  issue_valid & issue_ready; drives tracker alu_valid

Behaviour:
- Reset (rst==0 at a clk edge):
  - issue_valid=0, issue_wfid=0, issue_branch=0.
  - rr_ptr=0, shadow mask=0, FSM=IDLE.
- Eligibility is combinational: eligible = wf_ready_arry & ~pending_branches_arry & ~shadow.
- Pick: the first eligible index at or after rr_ptr, scanning upward with wrap from WF_PER_CU-1 to 0.
- FSM IDLE:
  - If any bit is eligible, register the pick: next cycle issue_valid=1, issue_wfid=pick, issue_branch=wf_branch_arry[pick]. Go to GRANT.
  - Otherwise stay in IDLE.
  - Latency from eligibility to issue_valid: 1 cycle.
- FSM GRANT:
  - issue_wfid and issue_branch are held stable until issue_ready=1.
  - A grant is never revoked because wf_ready drops; the kill rule below is the only exception.
- On fire (issue_valid & issue_ready):
  - rr_ptr = issue_wfid+1, wrapping 39 -> 0.
  - If issue_branch=1, set shadow[issue_wfid].
  - Go to IDLE. Back-to-back grants are therefore every 2 cycles at best.
- Shadow clear: shadow[i] clears on the cycle pending_branches_arry[i]==1 is observed. This covers the 1-cycle tracker latency, so a branch wavefront can never issue twice.
- Kill handling:
  - wf_kill_en clears shadow[wf_kill_wfid].
  - If the FSM is in GRANT to that wavefront and issue_ready=0, drop the grant: issue_valid=0 next cycle, FSM=IDLE, rr_ptr unchanged.
  - Kill and fire in the same cycle: fire wins, and the shadow bit is not set.
- issue_fire is combinational.
- Out-of-range ids (>=WF_PER_CU) never appear on issue_wfid. Kill ids out of range are ignored.
- A reset asserted mid-GRANT discards the grant without producing issue_fire.

Optional Feature:
BRANCH_ARB_STALL_STATS_EN
- Defined: adds output stall_cnt[31:0].
  - Saturating count of cycles in IDLE where (wf_ready_arry & pending_branches_arry) != 0 and eligible == 0.
  - Reset to 0 when rst==0.
- Undefined: the port and counter are absent, with identical arbitration behaviour.

Decomposition:
- WF_PER_CU and WF_ID_LENGTH come from the shared global definitions. FSM state encodings (IDLE=0, GRANT=1) go in the issue definitions package.
- One sub-module: rr_priority_picker. It is combinational; inputs are the WF_PER_CU request vector and the pointer; outputs are found and index. It is built as a rotate, a find-first, and an add with modulo wrap.

Test Plan:
- Reset, then wf_ready bits {3,7}, no pending -> grant wfid 3; with issue_ready=1 -> rr_ptr=4, next grant wfid 7.
- Ready {5}, branch=1 -> fire at wfid 5; wf_ready[5] held with pending low for 1 cycle -> no regrant. Pending[5]=1 then 0 -> wfid 5 granted again.
- Grant wfid 39 fires -> rr_ptr wraps to 0. Ready {0,39} -> next grant wfid 0.
- Grant wfid 12 with issue_ready=0 for 4 cycles -> wfid and branch stay stable. wf_kill 12 -> issue_valid=0 next cycle, and no fire occurs.
- Ready all 40, pending all -> issue_valid stays 0. With stats enabled, stall_cnt increments by 1 each cycle.
- Kill and fire the same cycle on a branch grant -> issue_fire=1, and shadow stays 0.
